serial_addsub_digit: RTL and testbench
======================================

Name: serial_addsub_digit

Overview:
- Digit-serial adder/subtractor, parametrised successor to the bit-serial valid/last adder.
- Consumes one DIGIT_W-bit digit pair per valid cycle, least-significant digit first. Operands are framed by vld/last.
- Emits registered sum digits with matching valid/last, plus end-of-operand carry, signed-overflow and digit count.
- Sits between serial operand sources and a serial result sink in the datapath.

Parameters:
- DIGIT_W, 4, bits per digit (>=1); DIGIT_W=1 gives bit-serial operation.
- MAX_DIGITS, 16, maximum digits per operand; sets width of the digit counter and the len output.
- CNT_W, $clog2(MAX_DIGITS+1), width of len (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- vld  input  1  input digit pair valid.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- last  input  1  final (most-significant) digit of operand; honoured only with vld.
- sub  input  1  0=A+B, 1=A-B; sampled only on the first digit of an operand.
- out_vld  output  1  sum digit valid.
- sum  output  DIGIT_W  result digit.
- out_last  output  1  final result digit.
- carry_out  output  1  unsigned carry (add) / no-borrow (sub); valid with out_vld&out_last.
- overflow  output  1  two's-complement signed overflow; valid with out_vld&out_last.
- len  output  CNT_W  digits in completed operand; valid with out_vld&out_last.
- err  output  1  sticky: operand exceeded MAX_DIGITS; cleared only by reset.

Behaviour:
- Reset (rst=0, async): carry=0, first=1, mode=0, cnt=0. All outputs 0: out_vld, sum, out_last, carry_out, overflow, len, err.
- State:
  - first flag: IDLE/start-of-operand when 1, IN_OPERAND when 0.
  - carry register (1 bit).
  - latched mode.
  - digit counter cnt.
- Per cycle with vld=1:
  - eff_sub = first ? sub : mode.
  - b_eff = eff_sub ? ~b : b.
  - cin = first ? eff_sub : carry.
  - {c_next, s} = a + b_eff + cin, computed (DIGIT_W+1) bits wide.
  - Registered next edge: out_vld=1, sum=s, out_last=last.
  - If first: mode<=sub, first<=0.
  - cnt increments. If cnt would exceed MAX_DIGITS, err<=1 and cnt saturates.
- vld=1 with last=1:
  - carry_out<=c_next.
  - overflow<=(a[MSB] ~^ b_eff[MSB]) & (s[MSB] ^ a[MSB]).
  - len<=cnt+1 (saturated).
  - first<=1, carry<=0, cnt<=0: the next vld starts a new operand with no idle cycle required.
- vld=1 with last=0: carry<=c_next. carry_out, overflow and len are driven 0.
- vld=0: state holds, out_vld<=0, out_last<=0. sum, carry_out, overflow and len hold their last values (don't-care to the sink). last and sub are ignored.
- Latency: exactly 1 cycle from input digit to output digit. Throughput 1 digit/cycle, no backpressure.
- Single-digit operand (first & last in the same cycle): cin comes from sub, and len=1.
- sub changing mid-operand is ignored; the latched mode applies.
- Reset mid-operand aborts the operand. The next vld after reset release is treated as a first digit.

Test Plan:
- DIGIT_W=4 add: A=0x3A7 and B=0x1C9 as digits 7/9, A/C, 3/1, last on the 3rd digit. Required: sum digits 0,7,5, i.e. 0x570; carry_out=0; overflow=0; len=3; out_last on the 3rd output only.
- DIGIT_W=4 sub:
  - A=0x05, B=0x07, two digits: sum 0xFE, carry_out=0 (borrow), overflow=0.
  - A=0x80, B=0x01: sum 0x7F, overflow=1.
- Gaps and back-to-back operands:
  - Insert vld=0 bubbles between digits, using 0x3A7+0x1C9: result unchanged, out_vld low exactly during the bubbles.
  - Start a second operand (0xF+0x1, single digit) on the cycle after last: sum=0, carry_out=1, len=1.
  - Confirm no carry leaks between the two operands.
- last with vld=0 is ignored; sub toggled mid-operand is ignored: the operand completes with its original mode and correct sum.
- Assert rst low asynchronously mid-operand, between clock edges:
  - All outputs go 0 immediately.
  - After release, 0x2+0x3 yields sum 5 with carry_out=0.
- MAX_DIGITS=4: send 6 digits with last on the 6th. Required: err=1 and stays 1; len=4 (saturated); err clears only on reset.

Source files
------------

// File: rtl/serial_addsub_digit.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub_digit
// Brief   : Digit-serial adder/subtractor, LSD first, framed by vld/last.
// Revision: 1.0 - initial release
// ============================================================================
module serial_addsub_digit #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 16,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               last,
  input  logic               sub,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic [CNT_W-1:0]   len,
  output logic               err
);

  localparam int               c_MSB     = DIGIT_W - 1;
  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_IN_OP = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_carry;
  logic               r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_vld;
  logic [DIGIT_W-1:0] r_sum;
  logic               r_out_last;
  logic               r_carry_out;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_len;
  logic               r_err;

  logic               w_first;
  logic               w_eff_sub;
  logic [DIGIT_W-1:0] w_b_eff;
  logic               w_cin;
  logic [DIGIT_W:0]   w_total;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c;
  logic               w_ovf;
  logic               w_sat;
  logic [CNT_W-1:0]   w_cnt_next;

  // Subtraction is A + ~B + 1; the +1 enters as carry-in of the first digit.
  assign w_first    = (r_state == S_IDLE);
  assign w_eff_sub  = w_first ? sub : r_mode;
  assign w_b_eff    = w_eff_sub ? ~b : b;
  assign w_cin      = w_first ? w_eff_sub : r_carry;
  assign w_total    = {1'b0, a} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, w_cin};
  assign w_s        = w_total[DIGIT_W-1:0];
  assign w_c        = w_total[DIGIT_W];
  assign w_ovf      = ~(a[c_MSB] ^ w_b_eff[c_MSB]) & (w_s[c_MSB] ^ a[c_MSB]);
  assign w_sat      = (r_cnt == c_MAX_CNT);
  assign w_cnt_next = w_sat ? r_cnt : r_cnt + c_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_carry     <= 1'b0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_out_vld   <= 1'b0;
      r_sum       <= '0;
      r_out_last  <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_len       <= '0;
      r_err       <= 1'b0;
    end else if (vld) begin
      r_out_vld  <= 1'b1;
      r_sum      <= w_s;
      r_out_last <= last;
      if (w_first) begin
        r_mode <= sub;
      end
      if (w_sat) begin
        r_err <= 1'b1;
      end
      if (last) begin
        // Operand complete: publish status and rearm for a back-to-back operand.
        r_carry_out <= w_c;
        r_overflow  <= w_ovf;
        r_len       <= w_cnt_next;
        r_state     <= S_IDLE;
        r_carry     <= 1'b0;
        r_cnt       <= '0;
      end else begin
        r_carry_out <= 1'b0;
        r_overflow  <= 1'b0;
        r_len       <= '0;
        r_state     <= S_IN_OP;
        r_carry     <= w_c;
        r_cnt       <= w_cnt_next;
      end
    end else begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end
  end

  assign out_vld   = r_out_vld;
  assign sum       = r_sum;
  assign out_last  = r_out_last;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign len       = r_len;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_digit.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_addsub_digit
// Brief   : Self-checking bench, whole-operand arithmetic reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_addsub_digit;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       last = 1'b0;
  logic       sub = 1'b0;

  logic       out_vld, out_last, carry_out, overflow, err;
  logic [3:0] sum;
  logic [4:0] len;
  logic       o4_vld, o4_last, o4_cout, o4_ovf, o4_err;
  logic [3:0] o4_sum;
  logic [2:0] o4_len;

  int checks = 0;
  int errors = 0;

  // Model state and expected outputs
  logic       m_first = 1'b1;
  logic       m_mode = 1'b0;
  longint     m_A = 0, m_B = 0, m_res = 0;
  int         m_k = 0;
  logic       e_vld = 0, e_last = 0, e_cout = 0, e_ovf = 0, e_err16 = 0, e_err4 = 0;
  logic [3:0] e_sum = '0;
  logic [4:0] e_len16 = '0;
  logic [2:0] e_len4 = '0;

  serial_addsub_digit #(.DIGIT_W(4), .MAX_DIGITS(16)) dut (
    .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .last(last), .sub(sub),
    .out_vld(out_vld), .sum(sum), .out_last(out_last), .carry_out(carry_out),
    .overflow(overflow), .len(len), .err(err)
  );

  serial_addsub_digit #(.DIGIT_W(4), .MAX_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .vld(vld), .a(a), .b(b), .last(last), .sub(sub),
    .out_vld(o4_vld), .sum(o4_sum), .out_last(o4_last), .carry_out(o4_cout),
    .overflow(o4_ovf), .len(o4_len), .err(o4_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1; m_mode = 1'b0; m_k = 0; m_A = 0; m_B = 0; m_res = 0;
    e_vld = 0; e_last = 0; e_cout = 0; e_ovf = 0; e_err16 = 0; e_err4 = 0;
    e_sum = '0; e_len16 = '0; e_len4 = '0;
  endtask

  // Treats the operand seen so far as whole integers and derives each output digit from them.
  task automatic model(input logic v, input logic [3:0] av, input logic [3:0] bv,
                       input logic l, input logic s);
    longint mask, full, sa, sb, r, half;
    int n, nb;
    if (!v) begin
      e_vld = 0; e_last = 0;
      return;
    end
    if (m_first) begin
      m_mode = s; m_A = 0; m_B = 0; m_k = 0;
    end
    m_first = 1'b0;
    m_A = m_A | (longint'(av) << (4 * m_k));
    m_B = m_B | (longint'(bv) << (4 * m_k));
    n = m_k + 1; nb = 4 * n;
    mask = (longint'(1) << nb) - 1;
    full = m_mode ? m_A + ((~m_B) & mask) + 1 : m_A + m_B;
    m_res = full & mask;
    e_vld = 1; e_last = l;
    e_sum = 4'((full >> (4 * m_k)) & 15);
    if (n > 4)  m_err4_set();
    if (n > 16) e_err16 = 1;
    if (l) begin
      half = longint'(1) << (nb - 1);
      sa = (m_A >= half) ? m_A - (half << 1) : m_A;
      sb = (m_B >= half) ? m_B - (half << 1) : m_B;
      r = m_mode ? sa - sb : sa + sb;
      e_cout = full[nb];
      e_ovf = (r > half - 1) || (r < -half);
      e_len16 = 5'((n > 16) ? 16 : n);
      e_len4 = 3'((n > 4) ? 4 : n);
      m_first = 1'b1;
    end else begin
      e_cout = 0; e_ovf = 0; e_len16 = '0; e_len4 = '0;
    end
    m_k++;
  endtask

  task automatic m_err4_set();
    e_err4 = 1;
  endtask

  task automatic step(input logic v, input logic [3:0] av, input logic [3:0] bv,
                      input logic l, input logic s);
    vld = v; a = av; b = bv; last = l; sub = s;
    @(posedge clk);
    model(v, av, bv, l, s);
    @(negedge clk);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_out_vld", {o4_vld, out_vld}, 0);
    chk("rst_sum", {o4_sum, sum}, 0);
    chk("rst_last", {o4_last, out_last}, 0);
    chk("rst_status", {o4_cout, o4_ovf, carry_out, overflow}, 0);
    chk("rst_len", {o4_len, len}, 0);
    chk("rst_err", {o4_err, err}, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    chk("out_vld", out_vld, e_vld);
    chk("out_last", out_last, e_last);
    chk("sum", sum, e_sum);
    chk("carry_out", carry_out, e_cout);
    chk("overflow", overflow, e_ovf);
    chk("len", len, e_len16);
    chk("err", err, e_err16);
    chk("out_vld4", o4_vld, e_vld);
    chk("sum4", o4_sum, e_sum);
    chk("carry_out4", o4_cout, e_cout);
    chk("overflow4", o4_ovf, e_ovf);
    chk("len4", o4_len, e_len4);
    chk("err4", o4_err, e_err4);
  end

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 0x3A7 + 0x1C9 = 0x570
    step(1, 4'h7, 4'h9, 0, 0);
    step(1, 4'hA, 4'hC, 0, 0);
    step(1, 4'h3, 4'h1, 1, 0);
    chk("pin_add_res", m_res, 64'h570);
    chk("pin_add_cout_ovf_len", {e_cout, e_ovf, e_len16}, {2'b00, 5'd3});

    // 0x05 - 0x07 = 0xFE with borrow
    step(1, 4'h5, 4'h7, 0, 1);
    step(1, 4'h0, 4'h0, 1, 1);
    chk("pin_sub_res", m_res, 64'hFE);
    chk("pin_sub_cout_ovf", {e_cout, e_ovf}, 2'b00);

    // 0x80 - 0x01 = 0x7F, signed overflow
    step(1, 4'h0, 4'h1, 0, 1);
    step(1, 4'h8, 4'h0, 1, 1);
    chk("pin_sub_ovf_res", m_res, 64'h7F);
    chk("pin_sub_ovf", e_ovf, 1'b1);

    // Bubbles with stray last/sub, then a back-to-back single-digit operand
    step(1, 4'h7, 4'h9, 0, 0);
    step(0, 4'h3, 4'h1, 1, 1);
    step(1, 4'hA, 4'hC, 0, 1);
    step(0, 4'hF, 4'hF, 1, 1);
    step(1, 4'h3, 4'h1, 1, 1);
    chk("pin_bubble_res", m_res, 64'h570);
    step(1, 4'hF, 4'h1, 1, 0);
    chk("pin_b2b", {m_res[3:0], e_cout, e_len16}, {4'h0, 1'b1, 5'd1});

    // Abort mid-operand
    step(1, 4'h5, 4'h5, 0, 0);
    step(1, 4'h6, 4'h2, 0, 1);
    do_reset();
    step(1, 4'h2, 4'h3, 1, 0);
    chk("pin_after_rst", {e_sum, e_cout}, {4'h5, 1'b0});

    // Six digits into the MAX_DIGITS=4 instance
    for (int i = 0; i < 6; i++)
      step(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (i == 5), 0);
    chk("pin_sat", {e_err4, e_len4, e_err16, e_len16}, {1'b1, 3'd4, 1'b0, 5'd6});

    // Random operands with bubbles and mid-operand sub noise
    for (int op = 0; op < 300; op++) begin
      int nd;
      nd = $urandom_range(1, 7);
      for (int d = 0; d < nd; d++) begin
        while ($urandom_range(0, 3) == 0)
          step(0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        step(1, 4'($urandom), 4'($urandom), (d == nd - 1), 1'($urandom));
      end
    end

    do_reset();
    step(1, 4'h1, 4'h1, 1, 0);
    chk("err4_cleared", o4_err, 1'b0);
    step(0, 4'h0, 4'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
